wb_buttons: RTL
===============

Name: wb_buttons

Overview:
Wishbone slave in the user project that reads external pushbuttons/switches from mprj_io and presents them to the management core. It is the input-direction counterpart of the LED write-only peripheral. It synchronises and debounces N inputs, captures qualified rising/falling edges in sticky W1C flags, and optionally raises an interrupt. It sits on the Caravel user Wishbone bus next to the LED block.

Parameters:
BASE_ADDR, 32'h3000_0010, word-aligned base; block decodes a 16-byte window.
N_IN, 8, number of button inputs (1..16).
DB_CYCLES, 1000, consecutive stable clocks required to accept a new level (>=2); benches override with 4.
CNT_W, 10, debounce counter width; must satisfy 2**CNT_W >= DB_CYCLES.

Ports:
wb_clk_i  in  1  system clock, all logic on rising edge
wb_rst_i  in  1  asynchronous, active-high reset
wbs_cyc_i  in  1  bus cycle
wbs_stb_i  in  1  strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte lane selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
io_in  in  N_IN  raw button levels (asynchronous to wb_clk_i)
irq  out  1  level interrupt, active high

Behaviour:
- Reset (async, wb_rst_i=1): wbs_ack_o=0, wbs_dat_o=0, irq=0, sync flops=0, debounced state=0, counters=0, EDGE=0, CTRL=0, IRQ_EN=0.
- Sync: 2-flop synchroniser per bit; raw-to-sync latency 2 clocks.
- Debounce per bit: if sync==db, counter cleared; else counter increments; when mismatch and counter==DB_CYCLES-1, db<=sync and counter cleared. Any glitch back to db level clears counter. Total latency io_in change -> DATA change = 2+DB_CYCLES clocks.
- Edge detect: rise_evt = db 0->1 & CTRL.rise_en; fall_evt = db 1->0 & CTRL.fall_en; either sets EDGE bit (sticky).
- Register map (offset = adr[3:2], hit when adr[31:4]==BASE_ADDR[31:4]):
  0x0 DATA RO: [N_IN-1:0] debounced levels; writes ignored.
  0x4 EDGE W1C: writing 1 clears the bit; event in same cycle as clear wins (bit stays 1).
  0x8 CTRL RW: [N_IN-1:0] rise_en, [N_IN+15:16] fall_en.
  0xC IRQ_EN RW: [N_IN-1:0].
  Unused bits read 0. Writes honour wbs_sel_i per byte lane.
- Handshake: on cyc&stb&hit&!ack, ack=1 next clock for exactly one cycle with dat_o valid that cycle; dat_o=0 whenever ack=0. Write takes effect on the ack cycle. Back-to-back strobes: ack toggles, one ack per access (never two consecutive ack cycles). No hit -> no ack (bus default handles it).
- Reset mid-transaction: ack drops immediately; pending access lost.
- irq = |(EDGE & IRQ_EN), registered (1 clock after EDGE set).

Optional Feature:
WB_BUTTONS_IRQ_EN: defined -> IRQ_EN register and irq logic as above. Undefined -> IRQ_EN reads 0, writes ignored, irq tied 0; EDGE capture still works for polling.

Decomposition:
- Package wb_buttons_pkg: register offsets (OFF_DATA=0, OFF_EDGE=4, OFF_CTRL=8, OFF_IRQEN=12), CTRL field positions (FALL_SHIFT=16).
- Sub-module button_debounce (one bit: synchroniser + counter + db output + rise/fall pulses), instantiated N_IN times via generate.

Test Plan:
- Reset then read 0x3000_0010/14/18/1C -> all 0x0000_0000, ack single-cycle one clock after stb.
- DB_CYCLES=4: io_in[0] 0->1 held -> DATA reads 0x01 exactly 6 clocks after change; 3-clock pulse on io_in[1] -> DATA stays 0x00.
- CTRL=0x0000_0001, press/release bit0 -> EDGE=0x01 (rise only); CTRL=0x0001_0000 -> release sets EDGE=0x01, press does not.
- EDGE=0x05, write 0x04 to EDGE -> reads 0x01; write 0x01 in same cycle as new rise on bit0 -> EDGE bit0 remains 1.
- WB_BUTTONS_IRQ_EN defined: IRQ_EN=0x01, rise on bit0 -> irq=1 one clock after EDGE set; W1C clears -> irq=0 next clock. Undefined: irq stays 0, IRQ_EN reads 0.
- Write CTRL with sel=4'b0100, data 0x00FF_FFFF -> CTRL=0x00FF_0000 (N_IN=8); access at 0x3000_0020 -> no ack.

Source files
------------

// File: rtl/wb_buttons_pkg.sv
// Shared register map constants and helpers for the wb_buttons pushbutton reader.
package wb_buttons_pkg;

  localparam logic [3:0]  OFF_DATA   = 4'h0;
  localparam logic [3:0]  OFF_EDGE   = 4'h4;
  localparam logic [3:0]  OFF_CTRL   = 4'h8;
  localparam logic [3:0]  OFF_IRQEN  = 4'hC;
  localparam int unsigned FALL_SHIFT = 16;

  typedef enum logic [1:0] {
    REG_DATA  = 2'd0,
    REG_EDGE  = 2'd1,
    REG_CTRL  = 2'd2,
    REG_IRQEN = 2'd3
  } reg_sel_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int unsigned b = 0; b < 4; b++) m[8*b +: 8] = {8{sel[b]}};
    return m;
  endfunction

endpackage

// File: rtl/wb_buttons_if.sv
// Caravel user-bus Wishbone slave signals for wb_buttons; names kept from the legacy port list.
interface wb_buttons_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_buttons_debounce.sv
// One button bit: 2-flop synchroniser, stability counter, debounced level and
// single-cycle rise/fall pulses coincident with the debounced level change.
module button_debounce #(
  parameter int unsigned DB_CYCLES = 1000,
  parameter int unsigned CNT_W     = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic             sync;
  logic             accept;

  assign sync   = sync_q[1];
  assign accept = (sync != db) && (cnt == CNT_W'(DB_CYCLES - 1));
  assign rise   = accept & sync;
  assign fall   = accept & ~sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], raw};
  end

  // Any return to the current level restarts the stability count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (sync == db) begin
      cnt <= '0;
    end else if (accept) begin
      db  <= sync;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_buttons.sv
// Wishbone pushbutton reader: debounced levels, sticky W1C edge flags, optional
// level interrupt (compiled in with WB_BUTTONS_IRQ_EN).
module wb_buttons
  import wb_buttons_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0010,
  parameter int unsigned N_IN      = 8,
  parameter int unsigned DB_CYCLES = 1000,
  parameter int unsigned CNT_W     = 10
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_buttons_if.slave     wbs,
  input  logic [N_IN-1:0] io_in,
  output logic            irq
);

  logic [N_IN-1:0] db, rise, fall;
  logic [N_IN-1:0] rise_en_q, fall_en_q, edge_q, irqen_q, edge_clr;
  logic [31:0]     wmask, wdata, ctrl_rd, ctrl_wd, rd_data;
  logic            hit, access, wr;
  reg_sel_e        sel_reg;
  logic            unused_bits;

  for (genvar g = 0; g < N_IN; g++) begin : g_btn
    button_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_db (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .raw (io_in[g]),
      .db  (db[g]),
      .rise(rise[g]),
      .fall(fall[g])
    );
  end

  assign hit      = (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign access   = wbs.wbs_cyc_i & wbs.wbs_stb_i & hit & ~wbs.wbs_ack_o;
  assign wr       = access & wbs.wbs_we_i;
  assign sel_reg  = reg_sel_e'(wbs.wbs_adr_i[3:2]);
  assign wmask    = lane_mask(wbs.wbs_sel_i);
  assign wdata    = wbs.wbs_dat_i & wmask;
  assign ctrl_wd  = (ctrl_rd & ~wmask) | wdata;
  assign edge_clr = (wr && sel_reg == REG_EDGE) ? wdata[N_IN-1:0] : '0;

  assign unused_bits = &{1'b0, wbs.wbs_adr_i[1:0], ctrl_wd};

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[N_IN-1:0]            = rise_en_q;
    ctrl_rd[FALL_SHIFT +: N_IN]  = fall_en_q;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (wr && sel_reg == REG_CTRL) begin
      rise_en_q <= ctrl_wd[N_IN-1:0];
      fall_en_q <= ctrl_wd[FALL_SHIFT +: N_IN];
    end
  end

  // Set terms are OR-ed after the clear so a same-cycle event survives a W1C.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) edge_q <= '0;
    else          edge_q <= (edge_q & ~edge_clr) | (rise & rise_en_q) | (fall & fall_en_q);
  end

`ifdef WB_BUTTONS_IRQ_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irqen_q <= '0;
      irq     <= 1'b0;
    end else begin
      if (wr && sel_reg == REG_IRQEN)
        irqen_q <= (irqen_q & ~wmask[N_IN-1:0]) | wdata[N_IN-1:0];
      irq <= |(edge_q & irqen_q);
    end
  end
`else
  assign irqen_q = '0;
  assign irq     = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (sel_reg)
      REG_DATA:  rd_data[N_IN-1:0] = db;
      REG_EDGE:  rd_data[N_IN-1:0] = edge_q;
      REG_CTRL:  rd_data           = ctrl_rd;
      REG_IRQEN: rd_data[N_IN-1:0] = irqen_q;
      default:   rd_data           = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs.wbs_ack_o <= 1'b0;
      wbs.wbs_dat_o <= '0;
    end else begin
      wbs.wbs_ack_o <= access;
      wbs.wbs_dat_o <= access ? rd_data : '0;
    end
  end

endmodule
